// File: rtl/updown_pkg.sv
// -----------------------------------------------------------------------------
// updown_pkg
// Shared definitions for the parametrised up/down counter.
//   cnt_mode_e : boundary behaviour selector
//     CNT_WRAP (0) - roll over to the opposite end and pulse wrap
//     CNT_SAT  (1) - hold at the end value, never pulse wrap
// -----------------------------------------------------------------------------
package updown_pkg;

    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } cnt_mode_e;

endpackage : updown_pkg

// File: rtl/mod_up_down_counter.sv
// -----------------------------------------------------------------------------
// mod_up_down_counter
// General-purpose up/down counter with a configurable width and terminal value,
// wrap or saturate boundary mode, count enable, synchronous load and boundary
// flags. Used for timers, address generators and occupancy tracking.
//
// Parameters
//   WIDTH    counter width in bits (1..32)
//   MAX_VAL  terminal (highest) count value (1..2**WIDTH-1)
//   MODE     CNT_WRAP or CNT_SAT
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-low reset
//   en        in   count enable, one step per clock while high
//   up_down   in   direction, 1 = up, 0 = down
//   load      in   synchronous load strobe (takes priority over en)
//   load_val  in   value to load, clamped to MAX_VAL
//   out       out  current count (registered)
//   at_max    out  out == MAX_VAL, decoded from the register
//   at_min    out  out == 0, decoded from the register
//   wrap      out  registered one-cycle pulse when the count rolls over
// -----------------------------------------------------------------------------
module mod_up_down_counter
    import updown_pkg::*;
#(
    parameter int unsigned     WIDTH   = 4,
    parameter longint unsigned MAX_VAL = (64'd1 << WIDTH) - 64'd1,
    parameter cnt_mode_e       MODE    = CNT_WRAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             at_max,
    output logic             at_min,
    output logic             wrap
);

    // Illegal configurations stop elaboration.
    if (WIDTH < 32'd1 || WIDTH > 32'd32) begin : g_width_chk
        $error("mod_up_down_counter: WIDTH must be in 1..32");
    end

    if (MAX_VAL < 64'd1 || MAX_VAL > ((64'd1 << WIDTH) - 64'd1)) begin : g_max_chk
        $error("mod_up_down_counter: MAX_VAL must be in 1..2**WIDTH-1");
    end

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ZERO  = '0;
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;
    logic             wrap_q;
    logic             wrap_d;

    // Next-value mux and clamp. Every branch yields a value in 0..MAX_VAL, so
    // the register can never hold an out-of-range count.
    always_comb begin
        out_d  = out_q;
        wrap_d = 1'b0;
        if (load) begin
            // >= rather than > keeps the compare non-constant when MAX_VAL is
            // the all-ones value; the result is identical.
            out_d = (load_val >= MAX_V) ? MAX_V : load_val;
        end else if (en) begin
            if (up_down) begin
                if (out_q == MAX_V) begin
                    if (MODE == CNT_WRAP) begin
                        out_d  = ZERO;
                        wrap_d = 1'b1;
                    end
                end else begin
                    out_d = out_q + ONE;
                end
            end else begin
                if (out_q == ZERO) begin
                    if (MODE == CNT_WRAP) begin
                        out_d  = MAX_V;
                        wrap_d = 1'b1;
                    end
                end else begin
                    out_d = out_q - ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q  <= ZERO;
            wrap_q <= 1'b0;
        end else begin
            out_q  <= out_d;
            wrap_q <= wrap_d;
        end
    end

    // Flags depend only on the register, so no input reaches them combinationally.
    assign out    = out_q;
    assign wrap   = wrap_q;
    assign at_max = (out_q == MAX_V);
    assign at_min = (out_q == ZERO);

endmodule : mod_up_down_counter

// File: tb/tb_mod_up_down_counter.sv
module tb_mod_up_down_counter;
    import updown_pkg::*;

    localparam int W    = 4;
    localparam int MAXV = 9;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic         up_down;
    logic         load;
    logic [W-1:0] load_val;

    logic [W-1:0] w_out, s_out;
    logic         w_max, w_min, w_wrap;
    logic         s_max, s_min, s_wrap;

    mod_up_down_counter #(.WIDTH(W), .MAX_VAL(MAXV), .MODE(CNT_WRAP)) u_wrap (
        .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load),
        .load_val(load_val), .out(w_out), .at_max(w_max), .at_min(w_min),
        .wrap(w_wrap)
    );

    mod_up_down_counter #(.WIDTH(W), .MAX_VAL(MAXV), .MODE(CNT_SAT)) u_sat (
        .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load),
        .load_val(load_val), .out(s_out), .at_max(s_max), .at_min(s_min),
        .wrap(s_wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        int w_cnt;
        bit w_wr;
        int s_cnt;
        bit s_wr;
    } exp_t;

    exp_t exp_q[$];

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int m_wc = 0;
    bit m_ww = 0;
    int m_sc = 0;
    bit m_sw = 0;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Count rules written as plain integer arithmetic.
    function automatic int model_next(input int c, input bit sat, input bit e,
                                      input bit ud, input bit ld, input int lv,
                                      output bit wr);
        int n;
        wr = 1'b0;
        if (ld) return (lv > MAXV) ? MAXV : lv;
        if (!e) return c;
        n = ud ? c + 1 : c - 1;
        if (n > MAXV) begin
            if (sat) return MAXV;
            wr = 1'b1;
            return 0;
        end
        if (n < 0) begin
            if (sat) return 0;
            wr = 1'b1;
            return MAXV;
        end
        return n;
    endfunction

    task automatic step(input bit rn, input bit e, input bit ud, input bit ld,
                        input int lv);
        exp_t x;
        @(negedge clk);
        reset    = rn;
        en       = e;
        up_down  = ud;
        load     = ld;
        load_val = W'(lv);
        if (!rn) begin
            m_wc = 0; m_ww = 0; m_sc = 0; m_sw = 0;
        end else begin
            m_wc = model_next(m_wc, 1'b0, e, ud, ld, lv, m_ww);
            m_sc = model_next(m_sc, 1'b1, e, ud, ld, lv, m_sw);
        end
        x.w_cnt = m_wc; x.w_wr = m_ww; x.s_cnt = m_sc; x.s_wr = m_sw;
        exp_q.push_back(x);
    endtask

    task automatic check_reset_now(input string tag);
        check({tag, "_w_out"}, int'(w_out), 0);
        check({tag, "_w_min"}, int'(w_min), 1);
        check({tag, "_w_max"}, int'(w_max), 0);
        check({tag, "_w_wrap"}, int'(w_wrap), 0);
        check({tag, "_s_out"}, int'(s_out), 0);
        check({tag, "_s_min"}, int'(s_min), 1);
        check({tag, "_s_wrap"}, int'(s_wrap), 0);
    endtask

    // Monitor: the counter presents a result every cycle; compare after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("wrap_out",    int'(w_out),  e.w_cnt);
                check("wrap_wrap",   int'(w_wrap), int'(e.w_wr));
                check("wrap_at_max", int'(w_max),  int'(e.w_cnt == MAXV));
                check("wrap_at_min", int'(w_min),  int'(e.w_cnt == 0));
                check("sat_out",     int'(s_out),  e.s_cnt);
                check("sat_wrap",    int'(s_wrap), int'(e.s_wr));
                check("sat_at_max",  int'(s_max),  int'(e.s_cnt == MAXV));
                check("sat_at_min",  int'(s_min),  int'(e.s_cnt == 0));
            end
        end
    end

    initial begin
        reset = 1'b0; en = 1'b0; up_down = 1'b0; load = 1'b0; load_val = '0;
        #2;
        check_reset_now("por");

        // Up count through the wrap point
        step(0, 1, 1, 0, 0);
        for (int i = 0; i < 12; i++) step(1, 1, 1, 0, 0);

        // Down count from reset: first edge wraps to MAX_VAL
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) step(1, 1, 0, 0, 0);

        // Saturation: up 15 then down 12 from reset
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 15; i++) step(1, 1, 1, 0, 0);
        for (int i = 0; i < 12; i++) step(1, 1, 0, 0, 0);

        // Load clamp and load priority over counting
        step(1, 1, 1, 1, 12);
        step(1, 1, 1, 1, 3);
        step(1, 1, 0, 1, 15);
        step(1, 1, 1, 1, 0);

        // Hold at 5 while direction toggles
        step(1, 0, 0, 1, 5);
        for (int i = 0; i < 5; i++) step(1, 0, i[0], 0, 0);

        // Asynchronous reset between edges at out=7
        step(1, 0, 0, 1, 7);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_reset_now("async");
        m_wc = 0; m_ww = 0; m_sc = 0; m_sw = 0;
        step(0, 1, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        step(1, 1, 1, 0, 0);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 59) != 0),
                 ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) == 0),
                 int'($urandom_range(0, 15)));
        end

        @(posedge clk);
        #3;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_mod_up_down_counter
